// File: rtl/gray_updown_counter_n_pkg.sv
// Shared Gray-code helpers for the counter macros.
// bin2gray / gray2bin operate on a 16-bit word; narrower values zero-extend.
package gray_updown_counter_n_pkg;

  localparam int GRAY_MAX_W = 16;

  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_PRESET,
    OP_CLEAR,
    OP_LOAD,
    OP_INC,
    OP_DEC,
    OP_SAT
  } op_e;

  function automatic gray_word_t bin2gray(
    input gray_word_t b
  );
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero upper bits
  // leave narrower widths unaffected.
  function automatic gray_word_t gray2bin(
    input gray_word_t g
  );
    gray_word_t b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_updown_counter_n_if.sv
// Control and status bundle of the Gray up/down counter.
// master: drives D/LD/EN/UP/PS/CS; slave: drives Q/QB/TC.
interface gray_updown_counter_n_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] D;
  logic             LD;
  logic             EN;
  logic             UP;
  logic             PS;
  logic             CS;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] QB;
  logic             TC;

  modport master (
    output D, LD, EN, UP, PS, CS,
    input  Q, QB, TC
  );

  modport slave (
    input  D, LD, EN, UP, PS, CS,
    output Q, QB, TC
  );

endinterface

// File: rtl/gray_updown_counter_n_gray2bin.sv
// Combinational Gray-to-binary decoder, WIDTH bits.
// g: Gray input; b: binary output.
module gray2bin_n
  import gray_updown_counter_n_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] b
);

  gray_word_t g_w;
  gray_word_t b_w;

  assign g_w = gray_word_t'(g);
  assign b_w = gray2bin(g_w);
  assign b   = b_w[WIDTH-1:0];

endmodule

// File: rtl/gray_updown_counter_n.sv
// N-bit Gray up/down counter, wrap or saturate, with TC for cascading.
// Ports: CLK, CD (async clear), bus (slave: D/LD/EN/UP/PS/CS -> Q/QB/TC).
module gray_updown_counter_n
  import gray_updown_counter_n_pkg::*;
#(
  parameter int               WIDTH      = 4,
  parameter int               SATURATE   = 0,
  parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
  input logic                    CLK,
  input logic                    CD,
  gray_updown_counter_n_if.slave bus
);

  localparam logic [WIDTH-1:0] TERM_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] TERM_ZERO = '0;
  localparam bit               SAT_MODE  = (SATURATE != 0);

  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] b_nxt;
  logic [WIDTH-1:0] d_bin;
  logic [WIDTH-1:0] pre_bin;
  logic             at_top;
  logic             at_bot;
  logic             tc;
  op_e              op;

  gray_word_t       q_w;

  gray2bin_n #(
    .WIDTH (WIDTH)
  ) u_d_dec (
    .g (bus.D),
    .b (d_bin)
  );

  gray2bin_n #(
    .WIDTH (WIDTH)
  ) u_pre_dec (
    .g (PRESET_VAL),
    .b (pre_bin)
  );

  assign at_top = (b_q == TERM_ONES);
  assign at_bot = (b_q == TERM_ZERO);

  // TC looks only at EN/UP and the state, so
  // PS/CS/LD never disturb a cascade chain.
  assign tc = bus.EN
            & ((bus.UP & at_top)
            | (~bus.UP & at_bot));

  always_ff @(posedge CLK or posedge CD) begin
    if (CD) begin
      b_q <= '0;
    end else begin
      b_q <= b_nxt;
    end
  end

  // Terms are made mutually exclusive to encode
  // PS > CS > LD > EN.
  always_comb begin
    op = OP_HOLD;
    unique case (1'b1)
      bus.PS: begin
        op = OP_PRESET;
      end
      (!bus.PS && bus.CS): begin
        op = OP_CLEAR;
      end
      (!bus.PS && !bus.CS && bus.LD): begin
        op = OP_LOAD;
      end
      (!bus.PS && !bus.CS && !bus.LD
       && bus.EN): begin
        if (SAT_MODE && tc) begin
          op = OP_SAT;
        end else if (bus.UP) begin
          op = OP_INC;
        end else begin
          op = OP_DEC;
        end
      end
      default: begin
        op = OP_HOLD;
      end
    endcase
  end

  always_comb begin
    b_nxt = b_q;
    unique case (op)
      OP_PRESET: b_nxt = pre_bin;
      OP_CLEAR:  b_nxt = '0;
      OP_LOAD:   b_nxt = d_bin;
      OP_INC:    b_nxt = b_q + WIDTH'(1);
      OP_DEC:    b_nxt = b_q - WIDTH'(1);
      OP_SAT:    b_nxt = b_q;
      default:   b_nxt = b_q;
    endcase
  end

  assign q_w    = bin2gray(gray_word_t'(b_q));
  assign bus.Q  = q_w[WIDTH-1:0];
  assign bus.QB = b_q;
  assign bus.TC = tc;

endmodule

// File: tb/tb_gray_updown_counter_n.sv
// Directed bench for gray_updown_counter_n.
// Three instances: 4-bit wrap, 4-bit saturate, 8-bit wrap.
module tb_gray_updown_counter_n;

  logic CLK;
  logic CD;

  int n_cmp;
  int n_bad;

  gray_updown_counter_n_if #(.WIDTH(4)) w4 ();
  gray_updown_counter_n_if #(.WIDTH(4)) s4 ();
  gray_updown_counter_n_if #(.WIDTH(8)) w8 ();

  gray_updown_counter_n #(
    .WIDTH    (4),
    .SATURATE (0)
  ) u_w4 (
    .CLK (CLK),
    .CD  (CD),
    .bus (w4)
  );

  gray_updown_counter_n #(
    .WIDTH    (4),
    .SATURATE (1)
  ) u_s4 (
    .CLK (CLK),
    .CD  (CD),
    .bus (s4)
  );

  gray_updown_counter_n #(
    .WIDTH    (8),
    .SATURATE (0)
  ) u_w8 (
    .CLK (CLK),
    .CD  (CD),
    .bus (w8)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [3:0] seq4 [16] = '{
    4'b0000, 4'b0001, 4'b0011, 4'b0010,
    4'b0110, 4'b0111, 4'b0101, 4'b0100,
    4'b1100, 4'b1101, 4'b1111, 4'b1110,
    4'b1010, 4'b1011, 4'b1001, 4'b1000
  };

  logic [3:0] prev4;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    {w4.D, w4.LD, w4.EN, w4.UP, w4.PS, w4.CS} = '0;
    {s4.D, s4.LD, s4.EN, s4.UP, s4.PS, s4.CS} = '0;
    {w8.D, w8.LD, w8.EN, w8.UP, w8.PS, w8.CS} = '0;
    CD = 1'b1;
    #12;
    chk("rst_q", 32'(w4.Q), 32'h0);
    chk("rst_qb", 32'(w4.QB), 32'h0);
    chk("rst_tc", 32'(w4.TC), 32'h0);
    CD = 1'b0;

    // up count with wrap
    w4.EN = 1'b1;
    w4.UP = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("up_q%0d", i),
          32'(w4.Q), 32'(seq4[i]));
      chk($sformatf("up_qb%0d", i),
          32'(w4.QB), 32'(i));
      chk($sformatf("up_tc%0d", i),
          32'(w4.TC), 32'(i == 15));
      prev4 = w4.Q;
      tick();
      chk($sformatf("up_1bit%0d", i),
          32'($countones(prev4 ^ w4.Q)), 32'd1);
    end
    chk("up_wrap", 32'(w4.Q), 32'h0);

    // down count with wrap
    w4.UP = 1'b0;
    #1;
    chk("dn_tc0", 32'(w4.TC), 32'h1);
    tick();
    chk("dn_q1", 32'(w4.Q), 32'b1000);
    chk("dn_qb1", 32'(w4.QB), 32'b1111);
    chk("dn_tc1", 32'(w4.TC), 32'h0);
    tick();
    chk("dn_q2", 32'(w4.Q), 32'b1001);
    chk("dn_qb2", 32'(w4.QB), 32'b1110);

    // load and priority
    w4.EN = 1'b0;
    w4.LD = 1'b1;
    w4.D  = 4'b0110;
    tick();
    chk("ld_q", 32'(w4.Q), 32'b0110);
    chk("ld_qb", 32'(w4.QB), 32'b0100);
    w4.PS = 1'b1;
    w4.CS = 1'b1;
    w4.D  = 4'b0011;
    tick();
    chk("pri_q", 32'(w4.Q), 32'b1111);
    chk("pri_qb", 32'(w4.QB), 32'b1010);
    w4.PS = 1'b0;
    w4.LD = 1'b0;
    w4.EN = 1'b1;
    w4.UP = 1'b1;
    tick();
    chk("cs_q", 32'(w4.Q), 32'b0000);
    w4.CS = 1'b0;
    w4.EN = 1'b0;
    w4.LD = 1'b1;
    tick();
    chk("ld2_q", 32'(w4.Q), 32'b0011);

    // async reset mid-count
    w4.D = 4'b1101;
    tick();
    w4.LD = 1'b0;
    chk("ar_pre", 32'(w4.Q), 32'b1101);
    w4.EN = 1'b1;
    w4.UP = 1'b1;
    #2;
    CD = 1'b1;
    #1;
    chk("ar_q", 32'(w4.Q), 32'h0);
    chk("ar_qb", 32'(w4.QB), 32'h0);
    chk("ar_tc", 32'(w4.TC), 32'h0);
    tick();
    tick();
    chk("ar_hold", 32'(w4.Q), 32'h0);
    #2;
    CD = 1'b0;
    tick();
    chk("ar_rel", 32'(w4.Q), 32'b0001);
    w4.EN = 1'b0;

    // saturate
    s4.LD = 1'b1;
    s4.D  = 4'b1000;
    tick();
    s4.LD = 1'b0;
    chk("sat_ld", 32'(s4.Q), 32'b1000);
    s4.EN = 1'b1;
    s4.UP = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("sat_q%0d", i),
          32'(s4.Q), 32'b1000);
      chk($sformatf("sat_tc%0d", i),
          32'(s4.TC), 32'h1);
    end
    s4.UP = 1'b0;
    tick();
    chk("sat_rev", 32'(s4.Q), 32'b1001);
    s4.EN = 1'b0;
    s4.CS = 1'b1;
    tick();
    s4.CS = 1'b0;
    s4.EN = 1'b1;
    tick();
    chk("sat_bot", 32'(s4.Q), 32'b0000);
    chk("sat_bot_tc", 32'(s4.TC), 32'h1);
    s4.UP = 1'b1;
    tick();
    chk("sat_up", 32'(s4.Q), 32'b0001);
    s4.EN = 1'b0;

    // width 8
    w8.LD = 1'b1;
    w8.D  = 8'b1000_0000;
    tick();
    w8.LD = 1'b0;
    chk("w8_q", 32'(w8.Q), 32'h80);
    chk("w8_qb", 32'(w8.QB), 32'hff);
    w8.EN = 1'b1;
    w8.UP = 1'b1;
    #1;
    chk("w8_tc", 32'(w8.TC), 32'h1);
    tick();
    chk("w8_wrap", 32'(w8.Q), 32'h00);
    w8.EN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("w8_hold%0d", i),
          32'(w8.Q), 32'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gray_updown_counter_n.md
Name: gray_updown_counter_n

Overview:
Parametrised N-bit Gray-code up/down counter. Generalises the 4-bit Gray up counter macro with configurable width, a direction input, wrap or saturate mode, and a terminal-count output for cascading. It also exposes a binary view of the count. It sits in the macro behavioural library alongside the fixed-width counter macros and is used for async-FIFO pointers and low-glitch state sequencing.

Parameters:
WIDTH, 4, counter width in bits; legal range 2..16.
SATURATE, 0, 0 = wrap at terminal count; 1 = hold at terminal count.
PRESET_VAL, all ones (WIDTH bits), Gray-coded value loaded by PS.

Ports:
CLK  input  1  rising-edge clock; the block's only clock.
CD  input  1  reset, asynchronous, active-high; forces the counter to zero.
D  input  WIDTH  parallel load data, Gray-coded.
LD  input  1  synchronous parallel load.
EN  input  1  count enable.
UP  input  1  direction: 1 = up, 0 = down.
PS  input  1  synchronous preset to PRESET_VAL.
CS  input  1  synchronous clear.
Q  output  WIDTH  registered count, Gray-coded.
QB  output  WIDTH  binary equivalent of Q (combinational decode of the state).
TC  output  1  terminal count (combinational).

Behaviour:
- State: one WIDTH-bit register holding the binary count B. Q = B xor (B >> 1). QB = B.
- Reset: CD=1 forces B=0 asynchronously, so Q=0, QB=0 and TC=0 unless UP=0 and EN=1. Reset takes effect immediately mid-operation. The first update after CD deasserts happens on the next rising CLK.
- Synchronous priority at the rising CLK edge, highest first: PS > CS > LD > EN. With none of these asserted, the count holds.
- PS: B <= gray2bin(PRESET_VAL). PS together with CS gives the preset value.
- CS: B <= 0.
- LD: B <= gray2bin(D). Every WIDTH-bit pattern is a legal Gray code, so there is no illegal-state recovery.
- EN with UP=1: B <= B+1, modulo 2^WIDTH.
- EN with UP=0: B <= B-1, modulo 2^WIDTH.
- Wrap with SATURATE=0:
  - Up from Gray 10..0 (B = all ones) goes to 0.
  - Down from 0 goes to Gray 10..0.
- Saturate with SATURATE=1:
  - At B = all ones with UP=1, or B = 0 with UP=0, EN leaves B unchanged.
  - Reversing direction moves away from the limit normally.
- TC = EN and ((UP and B == all ones) or (not UP and B == 0)).
  - TC does not depend on PS, CS or LD.
  - Used for cascading: feed TC into the next stage's EN.
- Latency: one CLK from control input to Q and QB. TC and QB follow state combinationally.
- Exactly one Q bit toggles per count step. This includes the wrap transition.
- UP changing on the same edge as EN: the new UP value applies to that edge.

Decomposition:
- Shared package or include file holds:
  - function bin2gray(B) = B xor (B >> 1).
  - function gray2bin(G), a prefix-XOR from the MSB down.
  - These are shared with the other Gray-code macros.
- One natural sub-module: gray2bin_n (WIDTH parameter, purely combinational), used for the D and PRESET_VAL decode.
- The terminal-value constant {WIDTH{1'b1}} is local.

Test Plan:
1. Up count, wrap: WIDTH=4, CD pulse, then EN=1, UP=1 for 16 clocks.
   - Q runs 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, then back to 0000.
   - TC=1 only while Q=1000.
   - Checker confirms exactly one Q bit changes per step.
2. Down count, wrap: from Q=0000 with EN=1, UP=0.
   - TC=1 at 0000; next Q=1000 (QB=1111); then 1001 (QB=1110).
3. Priority and load:
   - LD=1, D=0110: Q=0110, QB=0100.
   - Then PS=1, CS=1, LD=1 on the same edge: Q=1111 (PRESET_VAL).
   - Then CS=1, EN=1: Q=0000.
4. Async reset mid-count: at Q=1101, assert CD between clock edges.
   - Q=0000 and QB=0000 before the next edge.
   - Clocks while CD=1 do not change Q.
   - After release with EN=1, UP=1: Q=0001.
5. Saturate: WIDTH=4, SATURATE=1, load D=1000.
   - EN=1, UP=1 for 3 clocks: Q stays 1000 and TC=1.
   - Then UP=0: Q=1001.
6. Width scaling: WIDTH=8.
   - Load D=10000000: QB=11111111.
   - EN=1, UP=1: Q=00000000.
   - Hold with EN=0: Q unchanged for 5 clocks.
